// File: rtl/vscale_md_iter.sv
// Iterative RISC-V M-extension multiply/divide unit retiring STEP bits per cycle.
// Shift-add multiply and restoring divide share one 2*XLEN accumulator.
module vscale_md_iter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_in_1,
  input  logic [XLEN-1:0] req_in_2,
  input  logic            kill,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result
);

  localparam int unsigned NSTEPS = XLEN / STEP;
  localparam int unsigned CNT_W  = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(NSTEPS - 1);
  localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {IDLE, COMPUTE, FINISH, DONE} state_t;

  state_t            state, state_next;
  logic [2:0]        op_q, op_next;
  logic              neg_q, neg_next;
  logic [XLEN-1:0]   mcand_q, mcand_next;
  logic [2*XLEN-1:0] acc_q, acc_next;
  logic [CNT_W-1:0]  cnt_q, cnt_next;
  logic [XLEN-1:0]   result_q, result_next;

  logic              sgn1, sgn2, req_neg, div0, ovf;
  logic [XLEN-1:0]   abs1, abs2;
  logic [2*XLEN-1:0] full;
  logic [XLEN-1:0]   quo, rem, fin_result;

  // STEP iterations of right-shifting shift-add: {hi, lo} starts as {0, multiplier}
  function automatic logic [2*XLEN-1:0] mul_steps(input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0]   mc);
    logic [2*XLEN-1:0] a;
    logic [XLEN:0]     sum;
    a = acc;
    for (int unsigned i = 0; i < STEP; i++) begin
      sum = {1'b0, a[2*XLEN-1:XLEN]} + (a[0] ? {1'b0, mc} : {(XLEN+1){1'b0}});
      a   = {sum, a[XLEN-1:1]};
    end
    return a;
  endfunction

  // STEP iterations of restoring division: {rem, quo} starts as {0, dividend}
  function automatic logic [2*XLEN-1:0] div_steps(input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0]   dv);
    logic [2*XLEN-1:0] a;
    logic [XLEN:0]     part;
    logic              qbit;
    a = acc;
    for (int unsigned i = 0; i < STEP; i++) begin
      part = {a[2*XLEN-1:XLEN], a[XLEN-1]};
      qbit = 1'b0;
      if (part >= {1'b0, dv}) begin
        part = part - {1'b0, dv};
        qbit = 1'b1;
      end
      a = {part[XLEN-1:0], a[XLEN-2:0], qbit};
    end
    return a;
  endfunction

  // Request decode: operand signedness, magnitudes, result sign and bypass cases
  always_comb begin
    sgn1 = req_in_1[XLEN-1] & (req_op == OP_MUL || req_op == OP_MULH ||
                               req_op == OP_MULHSU || req_op == OP_DIV || req_op == OP_REM);
    sgn2 = req_in_2[XLEN-1] & (req_op == OP_MUL || req_op == OP_MULH ||
                               req_op == OP_DIV || req_op == OP_REM);
    abs1 = sgn1 ? -req_in_1 : req_in_1;
    abs2 = sgn2 ? -req_in_2 : req_in_2;
    req_neg = (req_op == OP_REM) ? sgn1 : (sgn1 ^ sgn2);
    div0 = req_op[2] && (req_in_2 == '0);
    ovf  = (req_op == OP_DIV || req_op == OP_REM) &&
           (req_in_1 == MOST_NEG) && (req_in_2 == '1);
  end

  // Final sign correction and result selection
  always_comb begin
    full = neg_q ? -acc_q : acc_q;
    quo  = acc_q[XLEN-1:0];
    rem  = acc_q[2*XLEN-1:XLEN];
    fin_result = '0;
    case (op_q)
      OP_MUL:                         fin_result = full[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   fin_result = full[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:                fin_result = neg_q ? -quo : quo;
      OP_REM, OP_REMU:                fin_result = neg_q ? -rem : rem;
      default:                        fin_result = '0;
    endcase
  end

  always_comb begin
    state_next  = state;
    op_next     = op_q;
    neg_next    = neg_q;
    mcand_next  = mcand_q;
    acc_next    = acc_q;
    cnt_next    = cnt_q;
    result_next = result_q;
    case (state)
      IDLE: begin
        if (req_valid) begin
          op_next  = req_op;
          neg_next = req_neg;
          cnt_next = CNT_INIT;
          if (div0 || ovf) begin
            // Bypass results are preloaded so FINISH selects them unmodified
            neg_next   = 1'b0;
            acc_next   = div0 ? {req_in_1, {XLEN{1'b1}}} : {{XLEN{1'b0}}, req_in_1};
            state_next = FINISH;
          end else begin
            mcand_next = req_op[2] ? abs2 : abs1;
            acc_next   = {{XLEN{1'b0}}, (req_op[2] ? abs1 : abs2)};
            state_next = COMPUTE;
          end
        end
      end
      COMPUTE: begin
        acc_next = op_q[2] ? div_steps(acc_q, mcand_q) : mul_steps(acc_q, mcand_q);
        cnt_next = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_next = FINISH;
      end
      FINISH: begin
        result_next = fin_result;
        state_next  = DONE;
      end
      DONE: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (kill) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      result_q <= '0;
    end else begin
      state    <= state_next;
      result_q <= result_next;
    end
  end

  always_ff @(posedge clk) begin
    op_q    <= op_next;
    neg_q   <= neg_next;
    mcand_q <= mcand_next;
    acc_q   <= acc_next;
    cnt_q   <= cnt_next;
  end

  assign req_ready   = (state == IDLE);
  assign resp_valid  = (state == DONE);
  assign resp_result = result_q;

endmodule

// File: tb/tb_vscale_md_iter.sv
// Directed bench for vscale_md_iter: three instances (STEP=1,2,4) run the same vectors
// in turn, each checked against hand-computed results and latencies.
module tb_vscale_md_iter;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic        clk = 1'b0;
  logic        reset [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic [2:0]  req_op [3];
  logic [31:0] req_in_1 [3];
  logic [31:0] req_in_2 [3];
  logic        kill [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_result [3];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    vscale_md_iter #(.XLEN(32), .STEP(1 << g)) u_dut (
      .clk        (clk),
      .reset      (reset[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_op     (req_op[g]),
      .req_in_1   (req_in_1[g]),
      .req_in_2   (req_in_2[g]),
      .kill       (kill[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_result(resp_result[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request, wait (bounded) for resp_valid, check latency and result
  task automatic do_op(input int s, input string tag, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat_exp, input bit ack);
    int lat;
    string t;
    t = $sformatf("s%0d_%s", 1 << s, tag);
    @(negedge clk);
    req_valid[s] = 1'b1; req_op[s] = op; req_in_1[s] = a; req_in_2[s] = b;
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
    lat = 1;
    while (!resp_valid[s] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({t, "_lat"}, 32'(lat), 32'(lat_exp));
    chk(t, resp_result[s], exp);
    if (ack) begin
      resp_ready[s] = 1'b1;
      @(posedge clk); #1;
      resp_ready[s] = 1'b0;
      chk({t, "_ready"}, 32'(req_ready[s]), 32'd1);
      chk({t, "_vdrop"}, 32'(resp_valid[s]), 32'd0);
    end
  endtask

  // Count resp_valid cycles over a window where no response may appear
  task automatic quiet(input int s, input string tag, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (resp_valid[s]) seen++;
    end
    chk($sformatf("s%0d_%s", 1 << s, tag), 32'(seen), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      reset[i] = 1'b1; req_valid[i] = 1'b0; req_op[i] = 3'd0; req_in_1[i] = '0;
      req_in_2[i] = '0; kill[i] = 1'b0; resp_ready[i] = 1'b0;
    end

    for (int s = 0; s < 3; s++) begin
      int lc;
      string p;
      lc = 32 / (1 << s) + 2;
      p  = $sformatf("s%0d_", 1 << s);

      repeat (2) @(posedge clk);
      #1;
      chk({p, "rst_ready"}, 32'(req_ready[s]), 32'd1);
      chk({p, "rst_valid"}, 32'(resp_valid[s]), 32'd0);
      chk({p, "rst_result"}, resp_result[s], 32'd0);
      reset[s] = 1'b0;

      do_op(s, "mul",     MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, lc, 1'b1);
      do_op(s, "mulh",    MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, lc, 1'b1);
      do_op(s, "mulhu",   MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, lc, 1'b1);
      do_op(s, "mulhsu",  MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, lc, 1'b1);
      do_op(s, "divu0",   DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 2,  1'b1);
      do_op(s, "rem0",    REM,    32'd5,          32'd0,         32'd5,         2,  1'b1);
      do_op(s, "div_ovf", DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2,  1'b1);
      do_op(s, "rem_ovf", REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2,  1'b1);
      do_op(s, "rem_neg", REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, lc, 1'b1);
      do_op(s, "div_neg", DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, lc, 1'b1);
      do_op(s, "div_nd",  DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, lc, 1'b1);
      do_op(s, "divu",    DIVU,   32'd100,        32'd7,         32'd14,        lc, 1'b1);
      do_op(s, "remu",    REMU,   32'd100,        32'd7,         32'd2,         lc, 1'b1);

      // Back-pressure: response must hold steady while resp_ready is low
      do_op(s, "stall", MUL, 32'd3, 32'd5, 32'd15, lc, 1'b0);
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        chk($sformatf("%sstall_v%0d", p, k), 32'(resp_valid[s]), 32'd1);
        chk($sformatf("%sstall_r%0d", p, k), resp_result[s], 32'd15);
      end
      resp_ready[s] = 1'b1;
      @(posedge clk); #1;
      resp_ready[s] = 1'b0;
      chk({p, "stall_idle"}, 32'(req_ready[s]), 32'd1);
      chk({p, "stall_vdrop"}, 32'(resp_valid[s]), 32'd0);

      // Kill in the fifth COMPUTE cycle
      @(negedge clk);
      req_valid[s] = 1'b1; req_op[s] = MUL; req_in_1[s] = 32'd3; req_in_2[s] = 32'd5;
      @(posedge clk); #1;
      req_valid[s] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      kill[s] = 1'b1;
      @(posedge clk); #1;
      kill[s] = 1'b0;
      chk({p, "kill_ready"}, 32'(req_ready[s]), 32'd1);
      chk({p, "kill_valid"}, 32'(resp_valid[s]), 32'd0);
      quiet(s, "kill_quiet", lc + 5);

      // Kill together with a request in IDLE drops the request
      @(negedge clk);
      req_valid[s] = 1'b1; kill[s] = 1'b1; req_op[s] = DIVU; req_in_1[s] = 32'd9; req_in_2[s] = 32'd0;
      @(posedge clk); #1;
      req_valid[s] = 1'b0; kill[s] = 1'b0;
      chk({p, "kidle_ready"}, 32'(req_ready[s]), 32'd1);
      quiet(s, "kidle_quiet", 6);

      // Reset while DONE with resp_ready low
      do_op(s, "rst_done", DIVU, 32'd100, 32'd7, 32'd14, lc, 1'b0);
      reset[s] = 1'b1;
      @(posedge clk); #1;
      reset[s] = 1'b0;
      chk({p, "rdone_valid"}, 32'(resp_valid[s]), 32'd0);
      chk({p, "rdone_result"}, resp_result[s], 32'd0);
      chk({p, "rdone_ready"}, 32'(req_ready[s]), 32'd1);

      do_op(s, "post_rst", REMU, 32'd100, 32'd7, 32'd2, lc, 1'b1);
      reset[s] = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/vscale_md_iter.md
VSCALE_MD_ITER -- requirements
Module: vscale_md_iter

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, the operand and result width in bits.
REQ-002 The block SHALL have parameter STEP, default 1, the quotient/product bits retired per compute cycle; it must be 1, 2 or 4 and divide XLEN.
REQ-003 The block SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port req_valid  input  1  request present.
REQ-006 The block SHALL have port req_ready  output  1  block can accept a request.
REQ-007 The block SHALL have port req_op  input  3  RISC-V M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 The block SHALL have port req_in_1  input  XLEN  rs1 operand (multiplicand/dividend).
REQ-009 The block SHALL have port req_in_2  input  XLEN  rs2 operand (multiplier/divisor).
REQ-010 The block SHALL have port kill  input  1  abort the in-flight operation.
REQ-011 The block SHALL have port resp_valid  output  1  resp_result valid.
REQ-012 The block SHALL have port resp_ready  input  1  consumer accepts the response.
REQ-013 The block SHALL have port resp_result  output  XLEN  result.

Function
REQ-014 The block SHALL implement states IDLE, COMPUTE, FINISH, DONE; req_ready=1 only in IDLE, resp_valid=1 only in DONE.
REQ-015 Accept: on req_valid&&req_ready&&!kill in IDLE, the block SHALL latch the op, the absolute operands, the result sign and a counter of XLEN/STEP-1, then go to COMPUTE.
REQ-016 Signedness SHALL be taken from req_op: rs1 is signed for MUL, MULH, MULHSU, DIV, REM; rs2 is signed for MUL, MULH, DIV, REM.
REQ-017 Result sign SHALL be sign1^sign2 for multiply and DIV; sign1 for REM.
REQ-018 COMPUTE SHALL retire STEP bits per cycle of the unsigned 2*XLEN product or restoring quotient/remainder, decrement the counter, and go to FINISH in the cycle the counter equals 0.
REQ-019 FINISH SHALL negate the 2*XLEN product/quotient/remainder if the sign flag is set; MUL returns bits [XLEN-1:0], MULH/MULHSU/MULHU return bits [2*XLEN-1:XLEN]; the result is registered and the state goes to DONE.
REQ-020 Divide by zero SHALL bypass COMPUTE (IDLE->FINISH): DIV/DIVU result all-ones, REM/REMU result = req_in_1.
REQ-021 Signed overflow (DIV/REM, rs1=most-negative, rs2=all-ones) SHALL bypass COMPUTE: DIV result = rs1, REM result = 0.
REQ-022 Latency from accept edge to first resp_valid cycle SHALL be XLEN/STEP+2 cycles (34 at defaults), or 2 cycles for a bypass case.
REQ-023 DONE SHALL hold resp_valid and a stable resp_result until resp_valid&&resp_ready, then go to IDLE the next cycle.
REQ-024 kill SHALL force IDLE on the next edge from any state, discard the operation and emit no response; kill with req_valid in IDLE SHALL drop that request.
REQ-025 Result arithmetic SHALL be modulo 2^XLEN; the counter width SHALL be ceil(log2(XLEN/STEP)), minimum 1.

Reset
REQ-026 With reset high at a clock edge, the block SHALL enter IDLE, giving req_ready=1 and resp_valid=0, and resp_result and the internal result register SHALL be 0.
REQ-027 Reset SHALL override kill and any in-progress operation, including mid-COMPUTE and DONE with resp_ready low.
REQ-028 Operand and counter registers SHALL need no reset.

Verification
REQ-029 The bench SHALL check MUL 7 x 0xFFFFFFFD -> resp_result 0xFFFFFFEB, resp_valid first asserted 34 cycles after accept (defaults).
REQ-030 The bench SHALL check MULH 0x80000000 x 0x80000000 -> 0x40000000, and MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-031 The bench SHALL check DIVU 5 / 0 -> 0xFFFFFFFF, REM 5 % 0 -> 5, and DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, each with resp_valid 2 cycles after accept.
REQ-032 The bench SHALL check REM 0xFFFFFFF9 % 2 -> 0xFFFFFFFF and DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
REQ-033 The bench SHALL hold resp_ready low 10 cycles in DONE and check resp_valid and the result are stable, then check that IDLE and req_ready=1 follow one cycle after the handshake.
REQ-034 The bench SHALL assert kill at COMPUTE cycle 5 and check no response and req_ready=1 next cycle; it SHALL then assert reset in DONE and check resp_valid=0 and resp_result=0; it SHALL repeat all of the above with STEP=2 and STEP=4 and check identical results at the scaled latency.
